// File: rtl/seq_multiplier.sv
`timescale 1ns/1ps
// Multi-cycle shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Iterates on operand magnitudes, then applies the product sign in one fix-up cycle.
module seq_multiplier #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CW-1:0]     count_q, count_d;
    logic              neg_q, neg_d;
    logic [1:0]        op_q, op_d;

    logic              a_neg, b_neg;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        a_neg    = ((op == 2'b01) || (op == 2'b10)) && rs1[XLEN-1];
        b_neg    = (op == 2'b01) && rs2[XLEN-1];
        // Carry-out of the adder lands in sum[XLEN] and shifts into the accumulator MSB.
        sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        prod     = {acc_q, mplier_q};
        if (neg_q) begin
            prod = -prod;
        end

        state_d  = state_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        count_d  = count_q;
        neg_d    = neg_q;
        op_d     = op_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    op_d     = op;
                    mcand_d  = a_neg ? -rs1 : rs1;
                    mplier_d = b_neg ? -rs2 : rs2;
                    neg_d    = a_neg ^ b_neg;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                acc_d    = sum[XLEN:1];
                mplier_d = {sum[0], mplier_q[XLEN-1:1]};
                count_d  = count_q + 1'b1;
                if (count_q == CW'(XLEN - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!flush) begin
                    result_d = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                end
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
        endcase

        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            op_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;

endmodule
